// File: rtl/urv_defs.sv
// Shared definitions for the uRV writeback stage: load funct3 codes,
// FSM state encoding and the W-stage register payload.
package urv_defs;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned FUN_W = 3;

   localparam logic [FUN_W-1:0] FUN_LB  = 3'b000;
   localparam logic [FUN_W-1:0] FUN_LH  = 3'b001;
   localparam logic [FUN_W-1:0] FUN_LW  = 3'b010;
   localparam logic [FUN_W-1:0] FUN_LBU = 3'b100;
   localparam logic [FUN_W-1:0] FUN_LHU = 3'b101;

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } wb_state_e;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  value;
      logic             rd_write;
      logic             load;
      logic [FUN_W-1:0] fun;
      logic [1:0]       addr;
   } wb_entry_t;

endpackage

// File: rtl/urv_load_align.sv
// Load data formatter: picks the byte/halfword lane addressed by the load
// and sign- or zero-extends it according to funct3.
module urv_load_align
   import urv_defs::*;
(
   input  logic [FUN_W-1:0] fun_i,
   input  logic [1:0]       addr_i,
   input  logic [XLEN-1:0]  data_i,
   output logic [XLEN-1:0]  value_o
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c  = data_i[7:0];
      half_c  = addr_i[1] ? data_i[31:16] : data_i[15:0];
      value_o = data_i;

      case (addr_i)
         2'd0: byte_c = data_i[7:0];
         2'd1: byte_c = data_i[15:8];
         2'd2: byte_c = data_i[23:16];
         2'd3: byte_c = data_i[31:24];
         default: byte_c = data_i[7:0];
      endcase

      // Unlisted funct3 codes fall through to the full-word format
      case (fun_i)
         FUN_LB:  value_o = {{24{byte_c[7]}}, byte_c};
         FUN_LBU: value_o = {24'd0, byte_c};
         FUN_LH:  value_o = {{16{half_c[15]}}, half_c};
         FUN_LHU: value_o = {16'd0, half_c};
         FUN_LW:  value_o = data_i;
         default: value_o = data_i;
      endcase
   end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: holds the retiring instruction, waits for load data,
// and drives the register-file write port plus the W->X bypass.
module urv_writeback
   import urv_defs::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              x_valid_i,
   input  logic [REG_W-1:0]  x_rd_i,
   input  logic [XLEN-1:0]   x_rd_value_i,
   input  logic              x_rd_write_i,
   input  logic              x_load_i,
   input  logic [FUN_W-1:0]  x_fun_i,
   input  logic [1:0]        x_dm_addr_i,
   input  logic [XLEN-1:0]   dm_data_l_i,
   input  logic              dm_load_done_i,
   output logic              w_stall_o,
   output logic [REG_W-1:0]  rf_rd_o,
   output logic [XLEN-1:0]   rf_rd_value_o,
   output logic              rf_rd_store_o,
   output logic              w_bypass_rd_write_o,
   output logic [XLEN-1:0]   w_bypass_rd_value_o,
   output logic              w_valid_o
);

   wb_state_e state_q, state_d;
   logic      w_valid_q, w_valid_d;
   wb_entry_t w_q, w_d;
   logic [XLEN-1:0] load_value_c;

   urv_load_align u_load_align (
      .fun_i   (w_q.fun),
      .addr_i  (w_q.addr),
      .data_i  (dm_data_l_i),
      .value_o (load_value_c)
   );

   // Retire/stall decision and W capture; a captured load enters LOAD_WAIT
   // at the capture edge so nothing can overwrite it before its data returns.
   always_comb begin
      state_d       = state_q;
      w_valid_d     = w_valid_q;
      w_d           = w_q;
      w_stall_o     = 1'b0;
      w_valid_o     = 1'b0;
      rf_rd_o       = w_q.rd;
      rf_rd_value_o = w_q.load ? load_value_c : w_q.value;

      if (state_q == ST_LOAD_WAIT) begin
         if (dm_load_done_i) begin
            w_valid_o = w_valid_q;
            state_d   = ST_IDLE;
         end else begin
            w_stall_o = 1'b1;
         end
      end else if (w_valid_q) begin
         if (w_q.load) begin
            state_d = ST_LOAD_WAIT;
         end else begin
            w_valid_o = 1'b1;
         end
      end

      rf_rd_store_o = w_valid_o && w_q.rd_write && (w_q.rd != '0);

      if (w_valid_o) begin
         w_valid_d = 1'b0;
      end

      if (x_valid_i && !w_stall_o) begin
         w_valid_d    = 1'b1;
         w_d.rd       = x_rd_i;
         w_d.value    = x_rd_value_i;
         w_d.rd_write = x_rd_write_i;
         w_d.load     = x_load_i;
         w_d.fun      = x_fun_i;
         w_d.addr     = x_dm_addr_i;
         state_d      = x_load_i ? ST_LOAD_WAIT : ST_IDLE;
      end
   end

   assign w_bypass_rd_write_o = rf_rd_store_o;
   assign w_bypass_rd_value_o = rf_rd_value_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         w_valid_q <= 1'b0;
         w_q       <= '0;
      end else begin
         state_q   <= state_d;
         w_valid_q <= w_valid_d;
         w_q       <= w_d;
      end
   end

endmodule

// File: tb/tb_urv_writeback.sv
// Bench for urv_writeback: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level reference model.
module tb_urv_writeback;

   logic        clk_i;
   logic        rst_i;
   logic        x_valid_i;
   logic [4:0]  x_rd_i;
   logic [31:0] x_rd_value_i;
   logic        x_rd_write_i;
   logic        x_load_i;
   logic [2:0]  x_fun_i;
   logic [1:0]  x_dm_addr_i;
   logic [31:0] dm_data_l_i;
   logic        dm_load_done_i;
   logic        w_stall_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
   logic        rf_rd_store_o;
   logic        w_bypass_rd_write_o;
   logic [31:0] w_bypass_rd_value_o;
   logic        w_valid_o;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the single instruction currently owned by writeback
   bit        m_v;
   bit [4:0]  m_rd;
   bit [31:0] m_val;
   bit        m_wr;
   bit        m_ld;
   bit [2:0]  m_fun;
   bit [1:0]  m_addr;

   urv_writeback dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .x_valid_i           (x_valid_i),
      .x_rd_i              (x_rd_i),
      .x_rd_value_i        (x_rd_value_i),
      .x_rd_write_i        (x_rd_write_i),
      .x_load_i            (x_load_i),
      .x_fun_i             (x_fun_i),
      .x_dm_addr_i         (x_dm_addr_i),
      .dm_data_l_i         (dm_data_l_i),
      .dm_load_done_i      (dm_load_done_i),
      .w_stall_o           (w_stall_o),
      .rf_rd_o             (rf_rd_o),
      .rf_rd_value_o       (rf_rd_value_o),
      .rf_rd_store_o       (rf_rd_store_o),
      .w_bypass_rd_write_o (w_bypass_rd_write_o),
      .w_bypass_rd_value_o (w_bypass_rd_value_o),
      .w_valid_o           (w_valid_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic bit [31:0] ref_fmt(input bit [2:0] fun, input bit [1:0] addr,
                                         input bit [31:0] d);
      int unsigned b;
      int unsigned h;
      b = (d >> (32'(addr) * 8)) % 256;
      h = (addr >= 2'd2) ? (d >> 16) : (d % 65536);
      case (fun)
         3'd0:    return (b >= 128) ? b - 256 : b;
         3'd1:    return (h >= 32768) ? h - 65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return d;
      endcase
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, compare against model, then advance model
   task automatic step(input bit xv, input bit [4:0] rd, input bit [31:0] val,
                       input bit wr, input bit ld, input bit [2:0] fun,
                       input bit [1:0] addr, input bit done, input bit [31:0] data);
      bit        e_stall, e_valid, e_store;
      bit [31:0] e_value;
      @(negedge clk_i);
      x_valid_i      = xv;
      x_rd_i         = rd;
      x_rd_value_i   = val;
      x_rd_write_i   = wr;
      x_load_i       = ld;
      x_fun_i        = fun;
      x_dm_addr_i    = addr;
      dm_load_done_i = done;
      dm_data_l_i    = data;
      #1;
      e_stall = m_v && m_ld && !done;
      e_valid = m_v && (!m_ld || done);
      e_store = e_valid && m_wr && (m_rd != 5'd0);
      e_value = m_ld ? ref_fmt(m_fun, m_addr, data) : m_val;
      chk1("stall", w_stall_o, e_stall);
      chk1("w_valid", w_valid_o, e_valid);
      chk1("rf_store", rf_rd_store_o, e_store);
      chk1("byp_write", w_bypass_rd_write_o, e_store);
      if (e_store) begin
         chk32("rf_rd", 32'(rf_rd_o), 32'(m_rd));
         chk32("rf_value", rf_rd_value_o, e_value);
         chk32("byp_value", w_bypass_rd_value_o, e_value);
      end
      if (xv && !e_stall) begin
         m_v = 1'b1; m_rd = rd; m_val = val; m_wr = wr;
         m_ld = ld; m_fun = fun; m_addr = addr;
      end else if (e_valid) begin
         m_v = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i          = 1'b1;
      x_valid_i      = 1'b0;
      dm_load_done_i = 1'b0;
      #1;
      chk1("rst_stall", w_stall_o, 1'b0);
      chk1("rst_valid", w_valid_o, 1'b0);
      chk1("rst_store", rf_rd_store_o, 1'b0);
      chk1("rst_byp_wr", w_bypass_rd_write_o, 1'b0);
      chk32("rst_rd", 32'(rf_rd_o), 32'd0);
      chk32("rst_value", rf_rd_value_o, 32'd0);
      chk32("rst_byp_val", w_bypass_rd_value_o, 32'd0);
      m_v = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   localparam logic [31:0] LD_DATA = 32'h80F1_7F82;

   initial begin
      rst_i = 1'b1; x_valid_i = 1'b0; x_rd_i = '0; x_rd_value_i = '0;
      x_rd_write_i = 1'b0; x_load_i = 1'b0; x_fun_i = '0; x_dm_addr_i = '0;
      dm_data_l_i = '0; dm_load_done_i = 1'b0;
      m_v = 1'b0; m_rd = '0; m_val = '0; m_wr = 1'b0; m_ld = 1'b0; m_fun = '0; m_addr = '0;
      do_reset();

      // ALU retire
      step(1, 5'd5, 32'hDEADBEEF, 1, 0, 3'd0, 2'd0, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 0, 32'h0);
      chk1("alu_store", rf_rd_store_o, 1'b1);
      chk32("alu_rd", 32'(rf_rd_o), 32'd5);
      chk32("alu_byp", w_bypass_rd_value_o, 32'hDEADBEEF);

      // Write to x0 is suppressed but still retires
      step(1, 5'd0, 32'h1234, 1, 0, 3'd0, 2'd0, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 0, 32'h0);
      chk1("x0_valid", w_valid_o, 1'b1);
      chk1("x0_store", rf_rd_store_o, 1'b0);

      // rd_write=0 retires without writing
      step(1, 5'd9, 32'h55, 0, 0, 3'd0, 2'd0, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 0, 32'h0);
      chk1("nowr_valid", w_valid_o, 1'b1);

      // Load formats, data returned one cycle after capture
      step(1, 5'd1, 32'h0, 1, 1, 3'b000, 2'd0, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 1, LD_DATA);
      chk32("lb_a0", rf_rd_value_o, 32'hFFFFFF82);
      step(1, 5'd2, 32'h0, 1, 1, 3'b100, 2'd1, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 1, LD_DATA);
      chk32("lbu_a1", rf_rd_value_o, 32'h0000007F);
      step(1, 5'd3, 32'h0, 1, 1, 3'b001, 2'd2, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 1, LD_DATA);
      chk32("lh_a2", rf_rd_value_o, 32'hFFFF80F1);
      step(1, 5'd4, 32'h0, 1, 1, 3'b101, 2'd0, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 1, LD_DATA);
      chk32("lhu_a0", rf_rd_value_o, 32'h00007F82);
      step(1, 5'd6, 32'h0, 1, 1, 3'b010, 2'd3, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 1, LD_DATA);
      chk32("lw", rf_rd_value_o, 32'h80F17F82);

      // Load wait of three cycles with an ALU op held on the X side
      step(1, 5'd7, 32'h0, 1, 1, 3'b010, 2'd0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1, 5'd9, 32'hCAFE0009, 1, 0, 3'd0, 2'd0, 0, 32'h0);
         chk1("wait_stall", w_stall_o, 1'b1);
      end
      step(1, 5'd9, 32'hCAFE0009, 1, 0, 3'd0, 2'd0, 1, 32'h13579BDF);
      chk1("done_store", rf_rd_store_o, 1'b1);
      chk1("done_stall", w_stall_o, 1'b0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 0, 32'h0);
      chk32("held_alu", rf_rd_value_o, 32'hCAFE0009);

      // Reset in LOAD_WAIT abandons the load; a late done is ignored
      step(1, 5'd8, 32'h0, 1, 1, 3'b010, 2'd0, 0, 32'h0);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 0, 32'h0);
      do_reset();
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 1, 32'hFFFFFFFF);
      chk1("late_done", rf_rd_store_o, 1'b0);

      // Back-to-back: ALU, ALU, load, ALU
      step(1, 5'd10, 32'hA, 1, 0, 3'd0, 2'd0, 0, 32'h0);
      step(1, 5'd11, 32'hB, 1, 0, 3'd0, 2'd0, 0, 32'h0);
      step(1, 5'd12, 32'h0, 1, 1, 3'b010, 2'd0, 0, 32'h0);
      step(1, 5'd13, 32'hD, 1, 0, 3'd0, 2'd0, 0, 32'h0);
      step(1, 5'd13, 32'hD, 1, 0, 3'd0, 2'd0, 1, 32'hC);
      step(0, 5'd0, 32'h0, 0, 0, 3'd0, 2'd0, 0, 32'h0);
      chk32("b2b_last", rf_rd_value_o, 32'hD);

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0,
                 3'($urandom),
                 2'($urandom),
                 $urandom_range(0, 2) == 0,
                 $urandom);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
